// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode stage: opcode, ALU and jump-class
// encodings, the per-instruction control bundle, and the opcode decoder.
package decode_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h02,
        OP_LDD  = 5'h10,
        OP_STD  = 5'h11,
        OP_POP  = 5'h12,
        OP_PUSH = 5'h13,
        OP_LDM  = 5'h14,
        OP_IN   = 5'h16,
        OP_OUT  = 5'h17,
        OP_JMP  = 5'h18
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_NOP    = 4'h0,
        ALU_ADD    = 4'h1,
        ALU_PASS_B = 4'h2
    } alu_op_e;

    typedef enum logic [2:0] {
        JT_NONE = 3'd0,
        JT_JMP  = 3'd1,
        JT_JZ   = 3'd2,
        JT_JN   = 3'd3,
        JT_JC   = 3'd4,
        JT_CALL = 3'd5,
        JT_RET  = 3'd6
    } jump_type_e;

    // Control bundle produced for one instruction. reads_rs/reads_rt tell the
    // hazard logic which source registers the instruction actually consumes.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       wb;
        logic       use_imm;
        logic       push;
        logic       pop;
        logic       in_port;
        logic       out_port;
        logic [2:0] jump_type;
        logic       reads_rs;
        logic       reads_rt;
    } ctrl_t;

    // Opcode to control mapping. Anything not listed behaves as a NOP.
    // Memory addresses for LDD/STD come straight from the immediate, so the
    // ALU simply passes operand B through for them.
    function automatic ctrl_t decode_op(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD: begin
                c.alu_op   = ALU_ADD;
                c.wb       = 1'b1;
                c.reads_rs = 1'b1;
                c.reads_rt = 1'b1;
            end
            OP_LDD: begin
                c.alu_op   = ALU_PASS_B;
                c.mem_read = 1'b1;
                c.wb       = 1'b1;
                c.use_imm  = 1'b1;
            end
            OP_STD: begin
                c.alu_op    = ALU_PASS_B;
                c.mem_write = 1'b1;
                c.use_imm   = 1'b1;
                c.reads_rs  = 1'b1;
            end
            OP_POP: begin
                c.mem_read = 1'b1;
                c.wb       = 1'b1;
                c.pop      = 1'b1;
            end
            OP_PUSH: begin
                c.mem_write = 1'b1;
                c.push      = 1'b1;
                c.reads_rs  = 1'b1;
            end
            OP_LDM: begin
                c.alu_op  = ALU_PASS_B;
                c.wb      = 1'b1;
                c.use_imm = 1'b1;
            end
            OP_IN: begin
                c.wb      = 1'b1;
                c.in_port = 1'b1;
            end
            OP_OUT: begin
                c.out_port = 1'b1;
                c.reads_rs = 1'b1;
            end
            OP_JMP: begin
                c.jump_type = JT_JMP;
                c.reads_rs  = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Register file with two asynchronous read ports and one write port. A read
// of the register being written in the same cycle returns the new data, so
// decode never sees a stale value from the WB stage.
module regfile_bypass #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage; every register clears on reset, none is hardwired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with write-through bypass.
    always_comb begin
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs_q[raddr_a];
        end
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs_q[raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: register read, opcode decode, load-use hazard detection with
// a one-cycle fetch stall, flush from execute, and the ID/EX pipeline register.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 3,
    parameter int INSTR_W     = 16,
    parameter int IMM_SIGNED  = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic                   flush,
    input  logic                   wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall_o,
    output logic                   ex_valid,
    output logic [3:0]             ex_alu_op,
    output logic [DATA_W-1:0]      ex_rs_data,
    output logic [DATA_W-1:0]      ex_rt_data,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [REG_ADDR_W-1:0]  ex_rd,
    output logic [REG_ADDR_W-1:0]  ex_rs,
    output logic [REG_ADDR_W-1:0]  ex_rt,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_wb,
    output logic                   ex_use_imm,
    output logic                   ex_push,
    output logic                   ex_pop,
    output logic                   ex_in_port,
    output logic                   ex_out_port,
    output logic [2:0]             ex_jump_type,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int PAD_W = DATA_W - 8;

    // Instruction fields; the rd and rs fields share bits [10:8].
    logic [4:0]            opcode_s;
    logic [REG_ADDR_W-1:0] rs_s;
    logic [REG_ADDR_W-1:0] rt_s;
    logic [7:0]            imm8_s;
    logic [DATA_W-1:0]     imm_ext_s;
    logic [DATA_W-1:0]     rs_data_s;
    logic [DATA_W-1:0]     rt_data_s;
    ctrl_t                 ctrl_s;
    logic                  hazard_s;
    logic                  load_bubble_s;

    // ID/EX pipeline register.
    logic                   ex_valid_q,     ex_valid_d;
    logic [3:0]             ex_alu_op_q,    ex_alu_op_d;
    logic [DATA_W-1:0]      ex_rs_data_q,   ex_rs_data_d;
    logic [DATA_W-1:0]      ex_rt_data_q,   ex_rt_data_d;
    logic [DATA_W-1:0]      ex_imm_q,       ex_imm_d;
    logic [REG_ADDR_W-1:0]  ex_rd_q,        ex_rd_d;
    logic [REG_ADDR_W-1:0]  ex_rs_q,        ex_rs_d;
    logic [REG_ADDR_W-1:0]  ex_rt_q,        ex_rt_d;
    logic                   ex_mem_read_q,  ex_mem_read_d;
    logic                   ex_mem_write_q, ex_mem_write_d;
    logic                   ex_wb_q,        ex_wb_d;
    logic                   ex_use_imm_q,   ex_use_imm_d;
    logic                   ex_push_q,      ex_push_d;
    logic                   ex_pop_q,       ex_pop_d;
    logic                   ex_in_port_q,   ex_in_port_d;
    logic                   ex_out_port_q,  ex_out_port_d;
    logic [2:0]             ex_jump_type_q, ex_jump_type_d;
    logic [STALL_CNT_W-1:0] stall_count_q,  stall_count_d;

    assign opcode_s = instruction[15:11];
    assign rs_s     = instruction[8 +: REG_ADDR_W];
    assign rt_s     = instruction[5 +: REG_ADDR_W];
    assign imm8_s   = instruction[7:0];
    assign ctrl_s   = decode_op(opcode_s);

    regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_s),
        .rdata_a (rs_data_s),
        .raddr_b (rt_s),
        .rdata_b (rt_data_s)
    );

    // Immediate extension chosen at elaboration time.
    always_comb begin
        if (IMM_SIGNED != 0) begin
            imm_ext_s = {{PAD_W{imm8_s[7]}}, imm8_s};
        end else begin
            imm_ext_s = {{PAD_W{1'b0}}, imm8_s};
        end
    end

    // Load-use hazard: a load (LDD or POP) in execute writes a register that
    // the instruction in decode reads. The bubble it causes clears the load
    // from ID/EX, so the stall lasts one cycle. A flush overrides the stall.
    always_comb begin
        hazard_s = if_valid & ex_valid_q & ex_mem_read_q & ex_wb_q &
                   ((ctrl_s.reads_rs & (ex_rd_q == rs_s)) |
                    (ctrl_s.reads_rt & (ex_rd_q == rt_s)));
        load_bubble_s = flush | hazard_s | ~if_valid;
    end

    assign stall_o = hazard_s & ~flush;

    // Next ID/EX contents: a bubble (all zero) or the decoded instruction.
    always_comb begin
        ex_valid_d     = 1'b0;
        ex_alu_op_d    = 4'h0;
        ex_rs_data_d   = '0;
        ex_rt_data_d   = '0;
        ex_imm_d       = '0;
        ex_rd_d        = '0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_wb_d        = 1'b0;
        ex_use_imm_d   = 1'b0;
        ex_push_d      = 1'b0;
        ex_pop_d       = 1'b0;
        ex_in_port_d   = 1'b0;
        ex_out_port_d  = 1'b0;
        ex_jump_type_d = 3'd0;
        if (load_bubble_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d     = 1'b1;
            ex_alu_op_d    = ctrl_s.alu_op;
            ex_rs_data_d   = rs_data_s;
            ex_rt_data_d   = rt_data_s;
            ex_imm_d       = imm_ext_s;
            ex_rd_d        = rs_s;
            ex_rs_d        = rs_s;
            ex_rt_d        = rt_s;
            ex_mem_read_d  = ctrl_s.mem_read;
            ex_mem_write_d = ctrl_s.mem_write;
            ex_wb_d        = ctrl_s.wb;
            ex_use_imm_d   = ctrl_s.use_imm;
            ex_push_d      = ctrl_s.push;
            ex_pop_d       = ctrl_s.pop;
            ex_in_port_d   = ctrl_s.in_port;
            ex_out_port_d  = ctrl_s.out_port;
            ex_jump_type_d = ctrl_s.jump_type;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall_o && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // ID/EX register and stall counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_alu_op_q    <= 4'h0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_wb_q        <= 1'b0;
            ex_use_imm_q   <= 1'b0;
            ex_push_q      <= 1'b0;
            ex_pop_q       <= 1'b0;
            ex_in_port_q   <= 1'b0;
            ex_out_port_q  <= 1'b0;
            ex_jump_type_q <= 3'd0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_wb_q        <= ex_wb_d;
            ex_use_imm_q   <= ex_use_imm_d;
            ex_push_q      <= ex_push_d;
            ex_pop_q       <= ex_pop_d;
            ex_in_port_q   <= ex_in_port_d;
            ex_out_port_q  <= ex_out_port_d;
            ex_jump_type_q <= ex_jump_type_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rd        = ex_rd_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_wb        = ex_wb_q;
    assign ex_use_imm   = ex_use_imm_q;
    assign ex_push      = ex_push_q;
    assign ex_pop       = ex_pop_q;
    assign ex_in_port   = ex_in_port_q;
    assign ex_out_port  = ex_out_port_q;
    assign ex_jump_type = ex_jump_type_q;
    assign stall_count  = stall_count_q;

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage for the 5-stage pipelined processor. It holds the register file with write-through bypass and the opcode-to-control decode, and registers everything into the ID/EX pipeline register. Unlike the previous decode stage, it detects load-use hazards and stalls fetch, accepts a flush from execute, carries a valid bit, and counts stall cycles. It sits between fetch (IF/ID register) and the execute stage; its writeback port is driven by the WB stage.

## Interface
Parameters:
- DATA_W, 16, register/data width
- REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W
- INSTR_W, 16, instruction width; fields: opcode [15:11], rd/rs [10:8], rt [7:5], imm [7:0]
- IMM_SIGNED, 0, 1 sign-extends imm to DATA_W, 0 zero-extends
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_valid  in  1  instruction is valid
- instruction  in  INSTR_W  instruction from IF/ID
- flush  in  1  branch taken in execute; kill the instruction in decode
- wb_en  in  1  register write enable from WB
- wb_addr  in  REG_ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_alu_op  out  4  ALU operation
- ex_rs_data, ex_rt_data  out  DATA_W  operand values
- ex_imm  out  DATA_W  extended immediate
- ex_rd, ex_rs, ex_rt  out  REG_ADDR_W  register addresses, for downstream forwarding
- ex_mem_read, ex_mem_write, ex_wb, ex_use_imm, ex_push, ex_pop, ex_in_port, ex_out_port  out  1 each  control
- ex_jump_type  out  3  jump class
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles

## Operation
- Register file: NUM_REGS x DATA_W, asynchronous read on rs and rt, written on the clk edge when wb_en is high. If wb_en is high and wb_addr equals the read address in the same cycle, the read returns wb_data (write-through). No register is hardwired to zero.
- Decode: a package function maps opcode to the control bundle, including reads_rs and reads_rt. Undefined opcodes decode as NOP: all controls 0.
- Load-use hazard: hazard = if_valid & ex_valid & ex_mem_read & ex_wb & ((reads_rs & ex_rd==rs) | (reads_rt & ex_rd==rt)). This covers LDD and POP.
- stall_o = hazard & ~flush.
- ID/EX update each edge, in priority order:
  - flush, hazard, or ~if_valid: load a bubble. All ex_* outputs are 0; data fields are don't-care, driven 0.
  - otherwise: load the decoded instruction with ex_valid=1.
- stall_count increments on each edge where stall_o=1. It saturates at all-ones.

## Timing
- Reset (asynchronous, any time, including mid-stall): every ex_* output, stall_count, and all registers go to 0. stall_o is therefore 0 after reset.
- Latency: an instruction accepted at edge N appears on ex_* after edge N.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read. The held instruction is accepted on the next edge.
- flush together with hazard: flush wins. stall_o=0, a bubble is loaded, and stall_count does not change.
- A wb write and a decode read of the same register at the same edge: decode sees wb_data.

## Structure
- Package decode_pkg holds:
  - opcode constants: OP_NOP=5'h00, OP_ADD=5'h02, OP_LDD=5'h10, OP_STD=5'h11, OP_POP=5'h12, OP_PUSH=5'h13, OP_LDM=5'h14, OP_IN=5'h16, OP_OUT=5'h17, OP_JMP=5'h18
  - the control-bundle struct
  - the decode function
  - jump-type constants
- Sub-module regfile_bypass: parametrised register file with write-through, async reset.
- Hazard logic, the ID/EX register, and the counter stay in the top module.

## Test plan
- Reset mid-stall: assert reset while stall_o=1 -> all ex_* = 0, stall_count=0, stall_o=0, and reading R0..R7 afterwards returns 0.
- Write-through: wb_en=1, wb_addr=3, wb_data=16'hBEEF in the same cycle as valid ADD R3,R5 -> next cycle ex_rs_data=16'hBEEF, ex_valid=1, ex_rd=3.
- Load-use: LDD R2 then ADD R2,R4 back-to-back -> stall_o=1 for one cycle and ex_valid=0 for one cycle; ADD appears one cycle later; stall_count=1. Repeat with POP R2 in place of LDD -> same result.
- No hazard:
  - LDD R2 then ADD R1,R4 -> stall_o stays 0 and ADD follows LDD directly.
  - STD R2 then ADD R2,R4 -> no stall.
- Flush priority: flush=1 while a load-use hazard is present -> stall_o=0, ex_valid=0 next cycle, stall_count unchanged.
- Immediate modes and saturation:
  - LDM imm=8'hF0 -> ex_imm=16'hFFF0 with IMM_SIGNED=1, 16'h00F0 with IMM_SIGNED=0.
  - STALL_CNT_W=2 with 5 load-use stalls -> stall_count=3.
